tt_um_carlosgs99_div_8by4: RTL
==============================

TT_UM_CARLOSGS99_DIV_8BY4 -- requirements
Module: tt_um_carlosgs99_div_8by4

Interface
REQ-001 SHALL: io_clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: io_rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL: io_start  input  1  request to start a division; sampled only in IDLE.
REQ-004 SHALL: io_N  input  8  unsigned dividend; sampled on the accepted start edge.
REQ-005 SHALL: io_D  input  4  unsigned divisor; sampled on the accepted start edge.
REQ-006 SHALL: io_Quotient  output  8  registered quotient of the last completed division.
REQ-007 SHALL: io_Remainder  output  4  registered remainder of the last completed division.
REQ-008 SHALL: io_busy  output  1  high in CALC state.
REQ-009 SHALL: io_done  output  1  one-cycle pulse in DONE state.
REQ-010 SHALL: io_dbz  output  1  divide-by-zero flag, valid while io_done is high.
REQ-011 SHALL: parameter BITS, default 4, divisor width; dividend width 2*BITS; only 4 is verified.

Function
REQ-012 SHALL: FSM states IDLE, CALC, DONE; IDLE -> CALC on io_start=1; CALC -> DONE after last iteration; DONE -> IDLE unconditionally.
REQ-013 SHALL: on accepted start, latch io_N/io_D into internal registers; clear partial remainder (5 bits) and iteration counter (3 bits).
REQ-014 SHALL: CALC performs one restoring step per cycle, MSB first: shift {rem, N[msb]} left; if rem >= D then rem -= D and quotient bit = 1, else bit = 0.
REQ-015 SHALL: exactly 8 CALC cycles; start sampled at edge 0 -> DONE entered at edge 8 -> io_done high from edge 8 to edge 9.
REQ-016 SHALL: io_Quotient/io_Remainder update only on DONE entry; they hold their value otherwise, including across later starts until the next DONE.
REQ-017 SHALL: results satisfy N = Q*D + R, R < D, for all D != 0.
REQ-018 SHALL: io_start while in CALC or DONE is ignored; no queuing; input changes after the start edge have no effect.
REQ-019 SHALL: io_start held high continuously yields back-to-back divisions: DONE -> IDLE -> CALC (one IDLE cycle between operations).
REQ-020 SHALL: D = 0 produces Q = 8'hFF, R = N[3:0].
REQ-021 SHALL: io_dbz = 0 whenever io_done = 0.

Reset
REQ-022 SHALL: io_rst_n low forces IDLE immediately, regardless of clock.
REQ-023 SHALL: reset values: io_Quotient=0, io_Remainder=0, io_busy=0, io_done=0, io_dbz=0, internal registers 0.
REQ-024 SHALL: reset mid-CALC abandons the operation with no io_done pulse; the first start after release operates normally.

Configuration
REQ-025 SHALL: macro DIV_ZERO_DETECT_EN selects divide-by-zero handling.
REQ-026 SHALL, when defined: D = 0 at start goes IDLE -> DONE directly, skipping CALC (latency 1 cycle); io_dbz=1 with io_done; results per REQ-020.
REQ-027 SHALL, when undefined: io_dbz tied 0; D = 0 runs the full 8 CALC cycles; results per REQ-020.

Verification
REQ-028 SHALL: N=200, D=7, start 1 cycle -> io_busy 8 cycles, io_done pulse at edge 8, Q=28, R=4, io_dbz=0.
REQ-029 SHALL: N=255, D=15 -> Q=17, R=0; N=5, D=9 -> Q=0, R=5; outputs hold until the next DONE.
REQ-030 SHALL: N=100, D=0 -> Q=255, R=4; with the macro: io_done 1 cycle after start, io_dbz=1; without it: io_done at edge 8, io_dbz=0.
REQ-031 SHALL: N=50, D=3 start, then start with N=9, D=2 at cycle 3 -> second start ignored; Q=16, R=2; single io_done pulse.
REQ-032 SHALL: N=200, D=7 start, io_rst_n low at cycle 4 -> all outputs 0 asynchronously, no io_done; after release, N=81, D=9 -> Q=9, R=0.
REQ-033 SHALL: exhaustive sweep of all 4096 N/D pairs with io_start held high -> every result matches REQ-017/REQ-020 and each op takes 10 cycles from start to start.

Source files
------------

// File: rtl/tt_um_carlosgs99_div_8by4.sv
// Multi-cycle restoring divider: 2*BITS-bit dividend / BITS-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN short-circuits divide-by-zero straight to DONE and raises io_dbz.
module tt_um_carlosgs99_div_8by4 #(
  parameter int BITS = 4
) (
  input  logic                io_clk,
  input  logic                io_rst_n,
  input  logic                io_start,
  input  logic [2*BITS-1:0]   io_N,
  input  logic [BITS-1:0]     io_D,
  output logic [2*BITS-1:0]   io_Quotient,
  output logic [BITS-1:0]     io_Remainder,
  output logic                io_busy,
  output logic                io_done,
  output logic                io_dbz
);

  localparam int NW = 2 * BITS;
  localparam int CW = $clog2(NW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic [BITS-1:0]   d_q, d_d;
  logic [BITS:0]     rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NW-1:0]     quot_q, quot_d;
  logic [NW-1:0]     q_out_q, q_out_d;
  logic [BITS-1:0]   r_out_q, r_out_d;
`ifdef DIV_ZERO_DETECT_EN
  logic              dbz_q, dbz_d;
`endif

  logic [BITS+1:0]   shifted;
  logic              ge;
  logic [BITS:0]     step_rem;

  // One restoring step: bring in the next dividend bit, subtract the divisor if it fits.
  always_comb begin
    shifted  = {rem_q, n_q[NW-1]};
    ge       = shifted >= {2'b00, d_q};
    step_rem = ge ? (BITS+1)'(shifted - {2'b00, d_q}) : shifted[BITS:0];
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (io_start) begin
          n_d    = io_N;
          d_d    = io_D;
          rem_d  = '0;
          cnt_d  = '0;
          quot_d = '0;
          state_d = CALC;
`ifdef DIV_ZERO_DETECT_EN
          dbz_d  = 1'b0;
          if (io_D == '0) begin
            state_d = DONE;
            q_out_d = '1;
            r_out_d = io_N[BITS-1:0];
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      CALC: begin
        rem_d  = step_rem;
        n_d    = n_q << 1;
        quot_d = {quot_q[NW-2:0], ge};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(NW - 1)) begin
          // Results are published only on DONE entry and hold until the next one.
          state_d = DONE;
          q_out_d = {quot_q[NW-2:0], ge};
          r_out_d = step_rem[BITS-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign io_Quotient  = q_out_q;
  assign io_Remainder = r_out_q;
  assign io_busy      = (state_q == CALC);
  assign io_done      = (state_q == DONE);
`ifdef DIV_ZERO_DETECT_EN
  assign io_dbz       = (state_q == DONE) && dbz_q;
`else
  assign io_dbz       = 1'b0;
`endif

endmodule
